// File: rtl/cpu_debug_cmd_sync.sv
// cpu_debug_cmd_sync
// System-clock side of the CPU debug slave. Two JTAG-domain toggle strobes
// (update-IR, exit1-DR) are synchronised into clk. Update-IR latches the
// instruction register. Exit1-DR captures {ir_lat, sr} into a small FIFO,
// which drives a valid/ready interface to the OCI debug logic. Each accepted
// command produces a one-cycle one-hot take_action / take_no_action pulse.
// Optional build macro: CPU_DEBUG_CMD_PARITY_EN. When it is defined, captures
// with odd parity are dropped and par_err is raised.

module cpu_debug_cmd_sync #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SR_W-1:0]           sr,
  input  logic [IR_W-1:0]           ir_in,
  input  logic                      vs_uir_tgl,
  input  logic                      vs_e1dr_tgl,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [SR_W-1:0]           cmd_data,
  output logic                      cmd_action,
  output logic [(2**IR_W)-1:0]      take_action,
  output logic [(2**IR_W)-1:0]      take_no_action,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overrun,
  input  logic                      err_clr,
  output logic                      par_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [SYNC_STAGES-1:0] r_uirSync;
  logic [SYNC_STAGES-1:0] r_e1drSync;
  logic                   r_uirDly;
  logic                   r_e1drDly;
  logic                   w_uirPulse;
  logic                   w_e1drPulse;

  logic [IR_W-1:0]        r_irLat;

  logic [IR_W-1:0]        r_memIr   [DEPTH];
  logic [SR_W-1:0]        r_memData [DEPTH];
  logic [AW:0]            r_wrPtr;
  logic [AW:0]            r_rdPtr;
  logic [AW:0]            w_level;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_parOk;
  logic                   w_overrunEvt;

  logic [(2**IR_W)-1:0]   r_takeAction;
  logic [(2**IR_W)-1:0]   r_takeNoAction;
  logic                   r_overrun;

  // Toggle synchronisers: each strobe runs through SYNC_STAGES flops and one delay flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uirSync  <= '0;
      r_e1drSync <= '0;
      r_uirDly   <= 1'b0;
      r_e1drDly  <= 1'b0;
    end else begin
      r_uirSync  <= {r_uirSync[SYNC_STAGES-2:0], vs_uir_tgl};
      r_e1drSync <= {r_e1drSync[SYNC_STAGES-2:0], vs_e1dr_tgl};
      r_uirDly   <= r_uirSync[SYNC_STAGES-1];
      r_e1drDly  <= r_e1drSync[SYNC_STAGES-1];
    end
  end

  assign w_uirPulse  = r_uirSync[SYNC_STAGES-1]  ^ r_uirDly;
  assign w_e1drPulse = r_e1drSync[SYNC_STAGES-1] ^ r_e1drDly;

  // IR latch: a capture in the same cycle still sees the previous value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irLat <= '0;
    end else if (w_uirPulse) begin
      r_irLat <= ir_in;
    end
  end

`ifdef CPU_DEBUG_CMD_PARITY_EN
  logic r_parErr;
  assign w_parOk = ~(^sr);

  // Sticky parity flag; clear wins over a same-cycle failing capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parErr <= 1'b0;
    end else if (err_clr) begin
      r_parErr <= 1'b0;
    end else if (w_e1drPulse && !w_parOk) begin
      r_parErr <= 1'b1;
    end
  end

  assign par_err = r_parErr;
`else
  assign w_parOk = 1'b1;
  assign par_err = 1'b0;
`endif

  assign w_level      = r_wrPtr - r_rdPtr;
  assign w_full       = (w_level == FULL_LVL);
  assign cmd_valid    = (w_level != '0);
  assign w_pop        = cmd_valid && cmd_ready;
  assign w_push       = w_e1drPulse && w_parOk && (!w_full || w_pop);
  assign w_overrunEvt = w_e1drPulse && w_parOk && w_full && !w_pop;

  // Command FIFO storage and pointers; a pop frees a slot for a same-cycle push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_memIr[i]   <= '0;
        r_memData[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_memIr[r_wrPtr[AW-1:0]]   <= r_irLat;
        r_memData[r_wrPtr[AW-1:0]] <= sr;
        r_wrPtr                    <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
    end
  end

  assign cmd_ir     = r_memIr[r_rdPtr[AW-1:0]];
  assign cmd_data   = r_memData[r_rdPtr[AW-1:0]];
  assign cmd_action = cmd_data[SR_W-1];
  assign fifo_level = w_level;

  // Sticky overrun flag; clear wins over a same-cycle dropped capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (err_clr) begin
      r_overrun <= 1'b0;
    end else if (w_overrunEvt) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;

  // One-hot take pulses, registered one cycle after the accepting handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_takeAction   <= '0;
      r_takeNoAction <= '0;
    end else begin
      r_takeAction   <= '0;
      r_takeNoAction <= '0;
      if (w_pop) begin
        if (cmd_action) begin
          r_takeAction[cmd_ir] <= 1'b1;
        end else begin
          r_takeNoAction[cmd_ir] <= 1'b1;
        end
      end
    end
  end

  assign take_action    = r_takeAction;
  assign take_no_action = r_takeNoAction;

endmodule

// File: tb/tb_cpu_debug_cmd_sync.sv
// Testbench for cpu_debug_cmd_sync: directed steps followed by random traffic.
// A command-level model predicts every output. It covers strobe latency, the
// FIFO, the sticky flags and the take pulses.
// Optional build macro: CPU_DEBUG_CMD_PARITY_EN (the model follows it).

module tb_cpu_debug_cmd_sync;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int NCH   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [SR_W-1:0]   sr;
  logic [IR_W-1:0]   ir_in;
  logic              vs_uir_tgl;
  logic              vs_e1dr_tgl;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [SR_W-1:0]   cmd_data;
  logic              cmd_action;
  logic [NCH-1:0]    take_action;
  logic [NCH-1:0]    take_no_action;
  logic [2:0]        fifo_level;
  logic              overrun;
  logic              err_clr;
  logic              par_err;

  cpu_debug_cmd_sync #(.SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
    .vs_uir_tgl(vs_uir_tgl), .vs_e1dr_tgl(vs_e1dr_tgl),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .cmd_action(cmd_action),
    .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .overrun(overrun), .err_clr(err_clr),
    .par_err(par_err)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } cmd_t;

  cmd_t           mq[$];
  int             uirDue[$];
  int             e1Due[$];
  logic           uirSeen;
  logic           e1Seen;
  logic [IR_W-1:0] mIrLat;
  logic           mOverrun;
  logic           mPar;
  logic [NCH-1:0] mTakeA;
  logic [NCH-1:0] mTakeN;
  int             cycle;
  int             total;
  int             bad;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    uirDue.delete();
    e1Due.delete();
    uirSeen  = 1'b0;
    e1Seen   = 1'b0;
    mIrLat   = '0;
    mOverrun = 1'b0;
    mPar     = 1'b0;
    mTakeA   = '0;
    mTakeN   = '0;
  endtask

  task automatic checkAll();
    checkOutput("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
    checkOutput("fifo_level", 64'(fifo_level), 64'(mq.size()));
    if (mq.size() != 0) begin
      checkOutput("cmd_ir", 64'(cmd_ir), 64'(mq[0].ir));
      checkOutput("cmd_data", 64'(cmd_data), 64'(mq[0].data));
      checkOutput("cmd_action", 64'(cmd_action), 64'(mq[0].data[SR_W-1]));
    end
    checkOutput("take_action", 64'(take_action), 64'(mTakeA));
    checkOutput("take_no_action", 64'(take_no_action), 64'(mTakeN));
    checkOutput("overrun", 64'(overrun), 64'(mOverrun));
    checkOutput("par_err", 64'(par_err), 64'(mPar));
  endtask

  // One clock: capture inputs, let the edge happen, update the model, check at negedge
  task automatic applyStimulus();
    logic [SR_W-1:0] cSr;
    logic [IR_W-1:0] cIr;
    logic            cUir, cE1, cReady, cClr;
    logic            uirNow, e1Now, pop, fullBefore, ovEvt, parEvt;
    cmd_t            head, nc;
    cSr = sr; cIr = ir_in; cUir = vs_uir_tgl; cE1 = vs_e1dr_tgl;
    cReady = cmd_ready; cClr = err_clr;
    @(posedge clk);
    cycle++;
    // A level change first seen at this edge takes effect SS edges later
    if (cUir !== uirSeen) begin uirDue.push_back(cycle + SS); uirSeen = cUir; end
    if (cE1 !== e1Seen) begin e1Due.push_back(cycle + SS); e1Seen = cE1; end
    uirNow = (uirDue.size() > 0) && (uirDue[0] == cycle);
    if (uirNow) void'(uirDue.pop_front());
    e1Now = (e1Due.size() > 0) && (e1Due[0] == cycle);
    if (e1Now) void'(e1Due.pop_front());
    fullBefore = (mq.size() == DEPTH);
    pop = (mq.size() > 0) && cReady;
    mTakeA = '0;
    mTakeN = '0;
    if (pop) begin
      head = mq.pop_front();
      if (head.data[SR_W-1]) mTakeA[head.ir] = 1'b1;
      else                   mTakeN[head.ir] = 1'b1;
    end
    ovEvt = 1'b0;
    parEvt = 1'b0;
    if (e1Now) begin
`ifdef CPU_DEBUG_CMD_PARITY_EN
      if (^cSr) parEvt = 1'b1;
      else
`endif
      if (fullBefore && !pop) ovEvt = 1'b1;
      else begin
        nc.ir = mIrLat;
        nc.data = cSr;
        mq.push_back(nc);
      end
    end
    if (uirNow) mIrLat = cIr;
    if (cClr) begin
      mOverrun = 1'b0;
      mPar = 1'b0;
    end else begin
      if (ovEvt) mOverrun = 1'b1;
      if (parEvt) mPar = 1'b1;
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Asserted at a negedge; outputs must clear without waiting for a clock
  task automatic doReset();
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    checkOutput("rst_fifo_level", 64'(fifo_level), 64'(0));
    checkOutput("rst_take_action", 64'(take_action), 64'(0));
    checkOutput("rst_take_no_action", 64'(take_no_action), 64'(0));
    checkOutput("rst_overrun", 64'(overrun), 64'(0));
    checkOutput("rst_par_err", 64'(par_err), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [SR_W-1:0] ovfData [5];

  // Directed sequence followed by randomized traffic
  initial begin
    total = 0; bad = 0; cycle = 0;
    sr = '0; ir_in = '0; vs_uir_tgl = 1'b0; vs_e1dr_tgl = 1'b0;
    cmd_ready = 1'b0; err_clr = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    doReset();
    $display("[TB] reset released");

    // IR latch, then an action command accepted immediately
    ir_in = 2'd1; vs_uir_tgl = ~vs_uir_tgl; steps(4);
    ir_in = 2'd2; vs_uir_tgl = ~vs_uir_tgl; steps(4);
    sr = 38'h20_0000_00AB; cmd_ready = 1'b1;
    vs_e1dr_tgl = ~vs_e1dr_tgl; steps(6);

    // No-action command held while not ready, then accepted
    cmd_ready = 1'b0;
    ir_in = 2'd3; vs_uir_tgl = ~vs_uir_tgl; steps(4);
    sr = 38'h00_1234_5678; vs_e1dr_tgl = ~vs_e1dr_tgl; steps(7);
    checkOutput("held_valid", 64'(cmd_valid), 64'(1));
    checkOutput("held_data", 64'(cmd_data), 64'h00_1234_5678);
    cmd_ready = 1'b1; steps(1);
    checkOutput("take_no_action_3", 64'(take_no_action), 64'(4'b1000));
    steps(2);

    // Overflow: five captures into a four-entry FIFO
    cmd_ready = 1'b0;
    ovfData[0] = 38'h3; ovfData[1] = 38'h5; ovfData[2] = 38'h20_0000_0006;
    ovfData[3] = 38'h9; ovfData[4] = 38'hA;
    for (int i = 0; i < 5; i++) begin
      sr = ovfData[i]; vs_e1dr_tgl = ~vs_e1dr_tgl; steps(2);
    end
    steps(4);
    checkOutput("ovf_level", 64'(fifo_level), 64'(4));
    checkOutput("ovf_overrun", 64'(overrun), 64'(1));
    cmd_ready = 1'b1; steps(6);
    cmd_ready = 1'b0;
    err_clr = 1'b1; steps(1); err_clr = 1'b0;
    checkOutput("ovf_cleared", 64'(overrun), 64'(0));

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 4; i++) begin
      sr = ovfData[i]; vs_e1dr_tgl = ~vs_e1dr_tgl; steps(2);
    end
    steps(3);
    sr = 38'h20_0000_0011; vs_e1dr_tgl = ~vs_e1dr_tgl;
    steps(2);
    cmd_ready = 1'b1; steps(1); cmd_ready = 1'b0;
    checkOutput("coinc_level", 64'(fifo_level), 64'(4));
    checkOutput("coinc_overrun", 64'(overrun), 64'(0));
    cmd_ready = 1'b1; steps(6); cmd_ready = 1'b0;

    // Odd-parity capture
    sr = 38'h1; vs_e1dr_tgl = ~vs_e1dr_tgl; steps(4);
`ifdef CPU_DEBUG_CMD_PARITY_EN
    checkOutput("par_level", 64'(fifo_level), 64'(0));
    checkOutput("par_flag", 64'(par_err), 64'(1));
`else
    checkOutput("par_level", 64'(fifo_level), 64'(1));
    checkOutput("par_flag", 64'(par_err), 64'(0));
`endif
    err_clr = 1'b1; steps(1); err_clr = 1'b0;
    cmd_ready = 1'b1; steps(2);

    // Reset while a take pulse is active and entries are queued
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sr = ovfData[i]; vs_e1dr_tgl = ~vs_e1dr_tgl; steps(2);
    end
    steps(3);
    cmd_ready = 1'b1; steps(1);
    doReset();
    cmd_ready = 1'b0;
    steps(4);

    // Randomized traffic with varying consumer pressure
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 150; i++) begin
        sr    = {6'($urandom), 32'($urandom)};
        ir_in = 2'($urandom);
        if ($urandom_range(0, 3) == 0) vs_uir_tgl = ~vs_uir_tgl;
        if ($urandom_range(0, 2) == 0) vs_e1dr_tgl = ~vs_e1dr_tgl;
        cmd_ready = ($urandom_range(0, 5) < seg);
        err_clr   = ($urandom_range(0, 29) == 0);
        applyStimulus();
      end
    end
    err_clr = 1'b0; cmd_ready = 1'b1;
    steps(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
